// File: rtl/uart_rx_buffered.sv
// Oversampled UART receiver with even-parity check, feeding a small FIFO drained by a pop handshake.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit instead of a single sample.
module uart_rx_buffered #(
  parameter int DATA_WIDTH = 16,
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int PARITY     = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  req_data,
  output logic [DATA_WIDTH-1:0] data_out_rx,
  output logic                  pending_data_rx,
  output logic                  parity_error_rx,
  output logic                  frame_error,
  output logic                  overflow
);

  // state   | meaning
  // S_IDLE  | waiting for a synchronized 1->0 edge on the line
  // S_START | checking the start bit at the decision tick
  // S_DATA  | shifting payload bits in, LSB first
  // S_PAR   | capturing the parity bit
  // S_STOP  | checking the stop bit, then push / frame error / overflow
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = $clog2(DIV + 1);
  localparam int SCNT_W  = $clog2(OVERSAMPLE);
  localparam int BCNT_W  = $clog2(DATA_WIDTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC     = OVERSAMPLE / 2 + 1;
`else
  localparam int DEC     = OVERSAMPLE / 2;
`endif

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [SCNT_W-1:0] DEC_C    = SCNT_W'(DEC);
  localparam logic [SCNT_W-1:0] OVS_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE = SCNT_W'(1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_WIDTH - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  // synchronizer and edge history
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // free-running tick: down-counter with terminal-count reload
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;

  assign tick = (div_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= tick ? DIV_LAST : (div_cnt_q - DIV_ONE);
  end

  state_t                state_q, state_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  rx_bit;
  logic                  decide;
  logic                  push_req;
  logic                  frame_err_d;

  assign decide = tick && (scnt_q == DEC_C);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SCNT_W-1:0] MAJ_A = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] MAJ_B = SCNT_W'(OVERSAMPLE / 2);
  logic [1:0] maj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_q <= 2'b11;
    end else if (tick && state_q != S_IDLE) begin
      if (scnt_q == MAJ_A) maj_q[0] <= rx_sync_q;
      if (scnt_q == MAJ_B) maj_q[1] <= rx_sync_q;
    end
  end

  // third sample is the live one at the decision tick
  assign rx_bit = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_sync_q) | (maj_q[1] & rx_sync_q);
`else
  assign rx_bit = rx_sync_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != S_IDLE && tick) begin
      scnt_d = (scnt_q == OVS_LAST) ? '0 : (scnt_q + SCNT_ONE);
    end

    case (state_q)
      S_IDLE: begin
        // edge (not level) start keeps a stuck-low line from retriggering
        if (rx_prev_q && !rx_sync_q) begin
          state_d = S_START;
          scnt_d  = '0;
        end
      end
      S_START: begin
        if (decide) begin
          if (rx_bit) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = rx_bit;
          bcnt_d                  = bcnt_q + BCNT_ONE;
          if (bcnt_q == BIT_LAST) begin
            perr_d  = 1'b0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (decide) begin
          perr_d  = (^shift_q) ^ rx_bit;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          state_d = S_IDLE;
          if (rx_bit) push_req    = 1'b1;
          else        frame_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: entries hold {parity_err, data}
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic                  full, empty, pop, push, ovf_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  perr_out_q, pending_q, frame_err_q, ovf_q;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign pop   = req_data && !empty;
  // a same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign push  = push_req && (!full || pop);
  assign ovf_d = push_req && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {perr_q, shift_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      perr_out_q  <= 1'b0;
      pending_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_ONE;
        data_out_q <= mem_q[rd_ptr_q][DATA_WIDTH-1:0];
        perr_out_q <= mem_q[rd_ptr_q][DATA_WIDTH];
      end
      count_q     <= count_d;
      pending_q   <= (count_d != '0);
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign data_out_rx     = data_out_q;
  assign parity_error_rx = perr_out_q;
  assign pending_data_rx = pending_q;
  assign frame_error     = frame_err_q;
  assign overflow        = ovf_q;

endmodule
